frac_clk_gen: RTL and testbench
===============================

Name: frac_clk_gen

Overview:
- Parametrised successor to the fixed two-output HDMI clock wrapper.
- Generates NUM_CLK derived clock-enable ticks and near-50%-duty square waves from one reference clock, using per-channel phase accumulators (fractional-N division).
- Channel rates are programmable at runtime over a valid/ready config port; `locked` drops on reconfiguration and reasserts after a settle interval.
- Feeds pixel/audio timing logic that needs slow clocks without consuming a hard PLL.

Parameters:
- NUM_CLK, 2, number of output channels (1..8).
- ACC_W, 32, accumulator/increment width in bits.
- LOCK_CYCLES, 16, refclk cycles from reset release or config apply until `locked` asserts (>=1).
- INC_INIT, {32'h051EB852, 32'h40000000}, NUM_CLK*ACC_W reset increments, channel 0 in the LSBs. Defaults give 12.5 MHz on ch0 and ~1 MHz on ch1 from 50 MHz.

Ports:
- refclk, in, 1: sole clock, all logic rising-edge.
- rst, in, 1: synchronous, active-high reset.
- cfg_valid, in, 1: config request.
- cfg_ready, out, 1: config accepted when cfg_valid && cfg_ready.
- cfg_ch, in, 3: target channel index.
- cfg_inc, in, ACC_W: new increment.
- cfg_err, out, 1: one-cycle pulse on an invalid request.
- tick, out, NUM_CLK: per-channel one-cycle enable on accumulator wrap.
- outclk, out, NUM_CLK: per-channel square wave, registered accumulator MSB.
- locked, out, 1: outputs stable at programmed rates.

Behaviour:
- Reset values, held while rst=1:
  - acc[i]=0, inc[i]=INC_INIT slice i.
  - tick=0, outclk=0, locked=0, cfg_ready=0, cfg_err=0.
  - state=SETTLE, settle counter=0.
- Datapath, every cycle with rst=0, for each channel i:
  - sum = acc[i] + inc[i], computed ACC_W+1 bits wide.
  - acc[i] <= sum mod 2^ACC_W.
  - tick[i] <= sum[ACC_W] (carry out).
  - outclk[i] <= acc[i][ACC_W-1].
  - Latency is 1 cycle from register to output.
- inc[i]=0: channel frozen, acc[i] held at 0, tick[i]=0, outclk[i]=0.
- Increment clamp:
  - inc > 2^(ACC_W-1) is stored as 2^(ACC_W-1), giving refclk/2.
  - The clamp pulses cfg_err, but the request is still applied.
- FSM states:
  - SETTLE:
    - Counter increments each cycle; cfg_ready=1, locked=0.
    - When counter==LOCK_CYCLES-1, go to LOCKED.
    - The first cycle after rst falls is counter 0, so `locked` is first 1 exactly LOCK_CYCLES cycles after reset release.
  - LOCKED: locked=1, cfg_ready=1.
  - APPLY:
    - Entered from SETTLE or LOCKED on an accepted request with cfg_ch < NUM_CLK. Lasts one cycle.
    - cfg_ready=0 and locked=0 in this cycle.
    - inc[cfg_ch] is written (clamped).
    - ALL accumulators are cleared, so channels stay phase-aligned.
    - tick is forced to 0 for this cycle.
    - Next state is SETTLE with the counter reset to 0.
- Invalid channel (cfg_ch >= NUM_CLK):
  - Request is accepted (handshake completes), but no state change.
  - cfg_err pulses the next cycle; locked is unaffected.
- Reconfig during SETTLE: accepted normally and restarts the settle count.
- Back-to-back requests: the second is stalled by cfg_ready=0 in APPLY and accepted the following cycle.
- rst asserted mid-operation: everything returns to reset values on the next edge, including INC_INIT (runtime config is lost).

Optional Feature:
- Macro FRAC_CLK_GATE_UNTIL_LOCK_EN.
- Defined: tick and outclk are forced to 0 whenever locked=0; accumulators still run. Consumers see no output until settled.
- Undefined: outputs toggle during SETTLE, and only APPLY forces tick=0.

Decomposition:
- Package frac_clk_pkg:
  - state enum {SETTLE, LOCKED, APPLY}.
  - Function clamp_inc(ACC_W).
  - Localparam HALF_INC = 1<<(ACC_W-1).
  - Settle counter width $clog2(LOCK_CYCLES+1).
- One sub-module, frac_clk_chan:
  - Holds one accumulator, its inc register, and the tick/outclk registers.
  - Inputs: clear, load, load_val.
  - Instantiated NUM_CLK times in a generate loop. The top holds the FSM and config handshake.

Test Plan:
- Reset release, defaults, 50 MHz:
  - locked rises exactly 16 cycles after rst falls.
  - tick[0] every 4 cycles; outclk[0] 2 high / 2 low.
  - tick[1] count over 10000 cycles = 200 ±1.
- Config ch1 inc=32'h80000000 while locked:
  - cfg_ready=0 for 1 cycle; locked low 17 cycles.
  - After APPLY, both accumulators restart at 0; tick[1] every 2 cycles.
- Config ch0 inc=32'hC0000000: cfg_err pulses, stored inc=32'h80000000, outclk[0] toggles every cycle.
- Config ch1 inc=0: tick[1]=0 and outclk[1]=0 permanently; ch0 unaffected apart from phase clear.
- Config cfg_ch=5: handshake completes, cfg_err pulses 1 cycle, locked stays 1, no rate or phase change.
- rst mid-SETTLE after a reconfig, with the macro defined:
  - All outputs return to 0 and INC_INIT is restored.
  - tick/outclk stay 0 until locked.
  - Repeat with the macro undefined: ticks appear during SETTLE.

Source files
------------

// File: rtl/frac_clk_pkg.sv
// Shared types and helpers for the fractional-N clock-enable generator.
// Optional build macro FRAC_CLK_GATE_UNTIL_LOCK_EN is consumed by frac_clk_gen.
package frac_clk_pkg;

   typedef enum logic [1:0] {
      SETTLE = 2'd0,
      LOCKED = 2'd1,
      APPLY  = 2'd2
   } state_t;

   // Widest accumulator the helpers below support.
   localparam int unsigned MAX_ACC_W = 64;

   // Anything faster than refclk/2 is meaningless for a square wave, so saturate there.
   function automatic logic [MAX_ACC_W-1:0] clamp_inc(input logic [MAX_ACC_W-1:0] inc,
                                                      input int unsigned          acc_w);
      logic [MAX_ACC_W-1:0] half;
      half = MAX_ACC_W'(1) << (acc_w - 1);
      return (inc > half) ? half : inc;
   endfunction

   function automatic int settle_cnt_w(input int lock_cycles);
      return $clog2(lock_cycles + 1);
   endfunction

endpackage

// File: rtl/frac_clk_chan.sv
// One phase-accumulator channel: carry-out gives the tick, registered MSB the square wave.
module frac_clk_chan #(
   parameter int               ACC_W   = 32,
   parameter logic [ACC_W-1:0] INC_RST = '0
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             clear,
   input  logic             load,
   input  logic [ACC_W-1:0] load_val,
   output logic             tick,
   output logic             outclk
);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] inc;
   logic [ACC_W:0]   sum;

   assign sum = {1'b0, acc} + {1'b0, inc};

   always_ff @(posedge refclk) begin
      if (rst) begin
         acc    <= '0;
         inc    <= INC_RST;
         tick   <= 1'b0;
         outclk <= 1'b0;
      end else begin
         if (load) begin
            inc <= load_val;
         end
         // A clear restarts the phase so every channel lines up after a reconfig.
         if (clear) begin
            acc    <= '0;
            tick   <= 1'b0;
            outclk <= 1'b0;
         end else begin
            acc    <= sum[ACC_W-1:0];
            tick   <= sum[ACC_W];
            outclk <= acc[ACC_W-1];
         end
      end
   end

endmodule

// File: rtl/frac_clk_gen.sv
// Multi-channel fractional-N clock-enable generator with runtime rate config and lock flag.
// Build macro FRAC_CLK_GATE_UNTIL_LOCK_EN: when defined, tick/outclk are held low until locked.
//
// state  | meaning
// SETTLE | counting LOCK_CYCLES after reset or reconfig, locked=0, config accepted
// LOCKED | outputs at programmed rates, locked=1, config accepted
// APPLY  | one cycle: write increment, clear all accumulators, tick suppressed
module frac_clk_gen
   import frac_clk_pkg::*;
#(
   parameter int                       NUM_CLK     = 2,
   parameter int                       ACC_W       = 32,
   parameter int                       LOCK_CYCLES = 16,
   parameter logic [NUM_CLK*ACC_W-1:0] INC_INIT    = {32'h051EB852, 32'h40000000}
) (
   input  logic               refclk,
   input  logic               rst,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [2:0]         cfg_ch,
   input  logic [ACC_W-1:0]   cfg_inc,
   output logic               cfg_err,
   output logic [NUM_CLK-1:0] tick,
   output logic [NUM_CLK-1:0] outclk,
   output logic               locked
);

   localparam int               CNT_W    = settle_cnt_w(LOCK_CYCLES);
   localparam logic [ACC_W-1:0] HALF_INC = ACC_W'(1) << (ACC_W - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             accept;
   logic             ch_ok;
   logic             over;
   logic             apply;
   logic [2:0]       cap_ch;
   logic [ACC_W-1:0] cap_inc;
   logic [ACC_W-1:0] inc_clamped;

   assign apply       = (state == APPLY);
   assign cfg_ready   = !rst && !apply;
   assign locked      = (state == LOCKED);
   assign accept      = cfg_valid && cfg_ready;
   assign ch_ok       = int'(cfg_ch) < NUM_CLK;
   assign over        = cfg_inc > HALF_INC;
   assign inc_clamped = ACC_W'(clamp_inc(MAX_ACC_W'(cfg_inc), ACC_W));

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         SETTLE: begin
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
               state_nxt = LOCKED;
            end
         end
         LOCKED: state_nxt = LOCKED;
         APPLY: begin
            state_nxt = SETTLE;
            cnt_nxt   = '0;
         end
         default: state_nxt = SETTLE;
      endcase
      // A valid request always wins, also restarting an ongoing settle.
      if (accept && ch_ok) begin
         state_nxt = APPLY;
         cnt_nxt   = '0;
      end
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         state   <= SETTLE;
         cnt     <= '0;
         cfg_err <= 1'b0;
         cap_ch  <= '0;
         cap_inc <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         cfg_err <= accept && (!ch_ok || over);
         if (accept && ch_ok) begin
            cap_ch  <= cfg_ch;
            cap_inc <= inc_clamped;
         end
      end
   end

   for (genvar i = 0; i < NUM_CLK; i++) begin : g_chan
      logic tick_q;
      logic outclk_q;

      frac_clk_chan #(
         .ACC_W   (ACC_W),
         .INC_RST (INC_INIT[i*ACC_W +: ACC_W])
      ) u_chan (
         .refclk   (refclk),
         .rst      (rst),
         .clear    (apply),
         .load     (apply && (cap_ch == 3'(i))),
         .load_val (cap_inc),
         .tick     (tick_q),
         .outclk   (outclk_q)
      );

`ifdef FRAC_CLK_GATE_UNTIL_LOCK_EN
      assign tick[i]   = tick_q & locked;
      assign outclk[i] = outclk_q & locked;
`else
      assign tick[i]   = tick_q & ~apply;
      assign outclk[i] = outclk_q;
`endif
   end

endmodule

// File: tb/tb_frac_clk_gen.sv
// Self-checking bench for frac_clk_gen against a closed-form phase model (n*inc mod 2^W).
module tb_frac_clk_gen;

   localparam int              NUM_CLK     = 2;
   localparam int              ACC_W       = 32;
   localparam int              LOCK_CYCLES = 16;
   localparam logic [63:0]     INC_INIT    = {32'h051EB852, 32'h40000000};
   localparam longint unsigned MOD         = 64'h1_0000_0000;
   localparam longint unsigned HALF        = 64'h8000_0000;
`ifdef FRAC_CLK_GATE_UNTIL_LOCK_EN
   localparam bit GATE = 1'b1;
`else
   localparam bit GATE = 1'b0;
`endif

   logic               refclk = 1'b0;
   logic               rst = 1'b1;
   logic               cfg_valid = 1'b0;
   logic               cfg_ready;
   logic [2:0]         cfg_ch = '0;
   logic [ACC_W-1:0]   cfg_inc = '0;
   logic               cfg_err;
   logic [NUM_CLK-1:0] tick;
   logic [NUM_CLK-1:0] outclk;
   logic               locked;

   always #5 refclk = ~refclk;

   frac_clk_gen #(
      .NUM_CLK     (NUM_CLK),
      .ACC_W       (ACC_W),
      .LOCK_CYCLES (LOCK_CYCLES),
      .INC_INIT    (INC_INIT)
   ) dut (
      .refclk    (refclk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_inc   (cfg_inc),
      .cfg_err   (cfg_err),
      .tick      (tick),
      .outclk    (outclk),
      .locked    (locked)
   );

   int n_pass = 0;
   int n_total = 0;

   // Reference model: edges since the last phase clear and since the last settle start.
   longint unsigned m_inc [NUM_CLK];
   int              since_clr = 0;
   int              since_settle = 0;
   bit              in_apply = 1'b0;
   bit              m_err = 1'b0;
   bit              m_acc = 1'b0;
   int              pend_ch = 0;
   longint unsigned pend_inc = 0;
   logic [6:0]      exp_v = '0;
   wire  [6:0]      got_v = {cfg_ready, locked, cfg_err, outclk, tick};

   task automatic step();
      bit              req;
      bit              e_locked;
      logic [1:0]      t;
      logic [1:0]      o;
      longint unsigned pa;
      longint unsigned pb;
      req = cfg_valid && !rst && !in_apply;
      @(posedge refclk);
      #1;
      m_acc = 1'b0;
      if (rst) begin
         since_clr = 0;
         since_settle = 0;
         in_apply = 1'b0;
         m_err = 1'b0;
         for (int i = 0; i < NUM_CLK; i++) m_inc[i] = 64'(INC_INIT[i*ACC_W +: ACC_W]);
      end else if (in_apply) begin
         since_clr = 0;
         since_settle = 0;
         in_apply = 1'b0;
         m_err = 1'b0;
         m_inc[pend_ch] = pend_inc;
      end else begin
         since_clr++;
         since_settle++;
         m_acc = req;
         m_err = req && (cfg_ch >= NUM_CLK || cfg_inc > HALF);
         if (req && cfg_ch < NUM_CLK) begin
            in_apply = 1'b1;
            pend_ch = int'(cfg_ch);
            pend_inc = (cfg_inc > HALF) ? HALF : 64'(cfg_inc);
         end
      end
      e_locked = !in_apply && since_settle >= LOCK_CYCLES;
      for (int i = 0; i < NUM_CLK; i++) begin
         if (since_clr == 0) begin
            t[i] = 1'b0;
            o[i] = 1'b0;
         end else begin
            pa = 64'(since_clr - 1) * m_inc[i];
            pb = 64'(since_clr) * m_inc[i];
            t[i] = (pb / MOD) != (pa / MOD);
            o[i] = (pa % MOD) >= HALF;
         end
         if (in_apply) t[i] = 1'b0;
         if (GATE && !e_locked) begin
            t[i] = 1'b0;
            o[i] = 1'b0;
         end
      end
      exp_v = {!rst && !in_apply, e_locked, m_err, o, t};
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic test_reset();
      int lock_at;
      int bad;
      logic [6:0] fg;
      logic [6:0] fe;
      rst = 1'b1;
      idle(3);
      n_total++;
      if (got_v !== 7'b0) $display("FAIL reset_values: got %b required 0000000", got_v);
      else n_pass++;
      rst = 1'b0;
      lock_at = -1;
      bad = 0;
      fg = '0;
      fe = '0;
      for (int c = 1; c <= 100 && lock_at < 0; c++) begin
         step();
         if (got_v !== exp_v) begin
            if (bad == 0) begin fg = got_v; fe = exp_v; end
            bad++;
         end
         if (locked === 1'b1) lock_at = c;
      end
      n_total++;
      if (lock_at != LOCK_CYCLES) $display("FAIL lock_latency: got %0d required %0d", lock_at, LOCK_CYCLES);
      else n_pass++;
      n_total++;
      if (bad != 0) $display("FAIL reset_release_trace: %0d bad cycles, first got %b required %b", bad, fg, fe);
      else n_pass++;
   endtask

   task automatic test_defaults();
      int bad;
      int t1;
      int last0;
      int gap_bad;
      logic [6:0] fg;
      logic [6:0] fe;
      bad = 0; t1 = 0; last0 = -1; gap_bad = 0; fg = '0; fe = '0;
      for (int c = 0; c < 10000; c++) begin
         step();
         if (got_v !== exp_v) begin
            if (bad == 0) begin fg = got_v; fe = exp_v; end
            bad++;
         end
         if (tick[1] === 1'b1) t1++;
         if (tick[0] === 1'b1) begin
            if (last0 >= 0 && c - last0 != 4) gap_bad++;
            last0 = c;
         end
      end
      n_total++;
      if (bad != 0) $display("FAIL defaults_trace: %0d bad cycles, first got %b required %b", bad, fg, fe);
      else n_pass++;
      n_total++;
      if (t1 < 199 || t1 > 201) $display("FAIL ch1_tick_count: got %0d required 200+-1", t1);
      else n_pass++;
      n_total++;
      if (gap_bad != 0 || last0 < 0) $display("FAIL ch0_tick_period: got %0d wrong gaps required 0", gap_bad);
      else n_pass++;
   endtask

   task automatic test_cfg_rate();
      int low;
      int bad;
      logic [6:0] fg;
      logic [6:0] fe;
      cfg_ch = 3'd1;
      cfg_inc = 32'h8000_0000;
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      n_total++;
      if (cfg_ready !== 1'b0) $display("FAIL apply_ready_low: got %b required 0", cfg_ready);
      else n_pass++;
      low = 1;
      bad = 0; fg = '0; fe = '0;
      for (int c = 0; c < 100 && locked !== 1'b1; c++) begin
         step();
         if (got_v !== exp_v) begin
            if (bad == 0) begin fg = got_v; fe = exp_v; end
            bad++;
         end
         if (locked !== 1'b1) low++;
      end
      for (int c = 0; c < 40; c++) begin
         step();
         if (got_v !== exp_v) begin
            if (bad == 0) begin fg = got_v; fe = exp_v; end
            bad++;
         end
      end
      n_total++;
      if (low != LOCK_CYCLES + 1) $display("FAIL relock_low_cycles: got %0d required %0d", low, LOCK_CYCLES + 1);
      else n_pass++;
      n_total++;
      if (bad != 0) $display("FAIL cfg_rate_trace: %0d bad cycles, first got %b required %b", bad, fg, fe);
      else n_pass++;
   endtask

   task automatic test_clamp();
      int bad;
      int tog_bad;
      logic prev;
      logic [6:0] fg;
      logic [6:0] fe;
      cfg_ch = 3'd0;
      cfg_inc = 32'hC000_0000;
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      n_total++;
      if (cfg_err !== 1'b1) $display("FAIL clamp_err_pulse: got %b required 1", cfg_err);
      else n_pass++;
      bad = 0; tog_bad = 0; prev = outclk[0]; fg = '0; fe = '0;
      for (int c = 0; c < 30; c++) begin
         step();
         if (got_v !== exp_v) begin
            if (bad == 0) begin fg = got_v; fe = exp_v; end
            bad++;
         end
         if (since_clr >= 2 && outclk[0] === prev) tog_bad++;
         prev = outclk[0];
      end
      n_total++;
      if (bad != 0) $display("FAIL clamp_trace: %0d bad cycles, first got %b required %b", bad, fg, fe);
      else n_pass++;
      n_total++;
      if (tog_bad != 0) $display("FAIL clamp_toggle: got %0d non-toggling cycles required 0", tog_bad);
      else n_pass++;
   endtask

   task automatic test_freeze();
      int bad;
      int hi;
      logic [6:0] fg;
      logic [6:0] fe;
      cfg_ch = 3'd1;
      cfg_inc = '0;
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      bad = 0; hi = 0; fg = '0; fe = '0;
      for (int c = 0; c < 60; c++) begin
         step();
         if (got_v !== exp_v) begin
            if (bad == 0) begin fg = got_v; fe = exp_v; end
            bad++;
         end
         if (tick[1] !== 1'b0 || outclk[1] !== 1'b0) hi++;
      end
      n_total++;
      if (hi != 0) $display("FAIL freeze_ch1: got %0d active cycles required 0", hi);
      else n_pass++;
      n_total++;
      if (bad != 0) $display("FAIL freeze_trace: %0d bad cycles, first got %b required %b", bad, fg, fe);
      else n_pass++;
   endtask

   task automatic test_invalid_ch();
      int bad;
      logic [6:0] fg;
      logic [6:0] fe;
      cfg_ch = 3'd5;
      cfg_inc = 32'h1234_5678;
      cfg_valid = 1'b1;
      n_total++;
      if (cfg_ready !== 1'b1) $display("FAIL invalid_ready: got %b required 1", cfg_ready);
      else n_pass++;
      step();
      cfg_valid = 1'b0;
      n_total++;
      if ({cfg_err, locked} !== 2'b11) $display("FAIL invalid_err_locked: got %b required 11", {cfg_err, locked});
      else n_pass++;
      bad = 0; fg = '0; fe = '0;
      for (int c = 0; c < 30; c++) begin
         step();
         if (got_v !== exp_v) begin
            if (bad == 0) begin fg = got_v; fe = exp_v; end
            bad++;
         end
      end
      n_total++;
      if (bad != 0) $display("FAIL invalid_trace: %0d bad cycles, first got %b required %b", bad, fg, fe);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [2:0] rdy;
      int bad;
      logic [6:0] fg;
      logic [6:0] fe;
      cfg_ch = 3'd0;
      cfg_inc = 32'h1000_0000;
      cfg_valid = 1'b1;
      step();
      rdy[2] = cfg_ready;
      cfg_ch = 3'd1;
      cfg_inc = 32'h2000_0000;
      step();
      rdy[1] = cfg_ready;
      step();
      rdy[0] = cfg_ready;
      cfg_valid = 1'b0;
      n_total++;
      if (rdy !== 3'b010) $display("FAIL b2b_ready_seq: got %b required 010", rdy);
      else n_pass++;
      bad = 0; fg = '0; fe = '0;
      for (int c = 0; c < 60; c++) begin
         step();
         if (got_v !== exp_v) begin
            if (bad == 0) begin fg = got_v; fe = exp_v; end
            bad++;
         end
      end
      n_total++;
      if (bad != 0) $display("FAIL b2b_trace: %0d bad cycles, first got %b required %b", bad, fg, fe);
      else n_pass++;
   endtask

   task automatic test_rst_mid_settle();
      int bad;
      int settle_ticks;
      int t0;
      logic [6:0] fg;
      logic [6:0] fe;
      cfg_ch = 3'd0;
      cfg_inc = 32'h2000_0000;
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      idle(4);
      rst = 1'b1;
      step();
      n_total++;
      if (got_v !== 7'b0) $display("FAIL mid_rst_values: got %b required 0000000", got_v);
      else n_pass++;
      rst = 1'b0;
      bad = 0; settle_ticks = 0; t0 = 0; fg = '0; fe = '0;
      for (int c = 0; c < 80; c++) begin
         step();
         if (got_v !== exp_v) begin
            if (bad == 0) begin fg = got_v; fe = exp_v; end
            bad++;
         end
         if (locked !== 1'b1 && tick !== '0) settle_ticks++;
         if (c >= 40 && tick[0] === 1'b1) t0++;
      end
      n_total++;
      if (bad != 0) $display("FAIL mid_rst_trace: %0d bad cycles, first got %b required %b", bad, fg, fe);
      else n_pass++;
      n_total++;
      if ((settle_ticks != 0) !== !GATE) $display("FAIL settle_ticks: got %0d gated=%0d", settle_ticks, GATE);
      else n_pass++;
      n_total++;
      if (t0 != 10) $display("FAIL inc_init_restored: got %0d ch0 ticks in 40 cycles required 10", t0);
      else n_pass++;
   endtask

   task automatic test_random();
      int bad;
      int gap;
      logic [6:0] fg;
      logic [6:0] fe;
      bad = 0; fg = '0; fe = '0;
      for (int op = 0; op < 120; op++) begin
         gap = int'($urandom_range(0, 25));
         for (int k = 0; k < gap; k++) begin
            step();
            if (got_v !== exp_v) begin
               if (bad == 0) begin fg = got_v; fe = exp_v; end
               bad++;
            end
         end
         if ($urandom_range(0, 9) == 0) begin
            rst = 1'b1;
            step();
            if (got_v !== exp_v) begin
               if (bad == 0) begin fg = got_v; fe = exp_v; end
               bad++;
            end
            rst = 1'b0;
         end else begin
            cfg_ch = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
               0: cfg_inc = '0;
               1: cfg_inc = $urandom;
               2: cfg_inc = $urandom_range(1, 32'h0800_0000);
               3: cfg_inc = 32'h8000_0000;
               default: cfg_inc = 32'h8000_0000 + $urandom_range(1, 32'h7FFF_FFFF);
            endcase
            cfg_valid = 1'b1;
            for (int k = 0; k < 10 && cfg_valid; k++) begin
               step();
               if (got_v !== exp_v) begin
                  if (bad == 0) begin fg = got_v; fe = exp_v; end
                  bad++;
               end
               if (m_acc) cfg_valid = 1'b0;
            end
            cfg_valid = 1'b0;
         end
      end
      n_total++;
      if (bad != 0) $display("FAIL random_trace: %0d bad cycles, first got %b required %b", bad, fg, fe);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_defaults();
      test_cfg_rate();
      test_clamp();
      test_freeze();
      test_invalid_ch();
      test_back_to_back();
      idle(20);
      test_rst_mid_settle();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
